// File: rtl/lcd_text_pkg.sv
// rtl/lcd_text_pkg.sv - shared constants, field positions and FSM states for the text buffer arbiter
package lcd_text_pkg;

  localparam int DEFAULT_DEPTH      = 2400;
  localparam int DEFAULT_ADDR_WIDTH = 12;
  localparam int DEFAULT_CHAR_WIDTH = 7;

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_SETADDR = 2'b01;
  localparam logic [1:0] OP_WRITE   = 2'b10;
  localparam logic [1:0] OP_CLEAR   = 2'b11;

  localparam int CMD_TOGGLE_BIT = 31;
  localparam int CMD_OP_LSB     = 29;
  localparam int CMD_ADDR_LSB   = 16;
  localparam int CMD_CHAR_LSB   = 0;

  localparam int STAT_ACK_BIT   = 31;
  localparam int STAT_BUSY_BIT  = 30;
  localparam int STAT_WADDR_LSB = 0;

  localparam int RESYNC_CYCLES = 3;

  typedef enum logic [1:0] {
    ST_RESYNC = 2'd0,
    ST_IDLE   = 2'd1,
    ST_EXEC   = 2'd2,
    ST_CLEAR  = 2'd3
  } state_e;

endpackage

// File: rtl/toggle_synchronizer.sv
// rtl/toggle_synchronizer.sv - two-flop synchronizer for the HPS command toggle
module toggle_synchronizer (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], async_in};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q[1];

endmodule

// File: rtl/text_buffer_arbiter.sv
// rtl/text_buffer_arbiter.sv - shares the character RAM between LCD scanout and HPS toggle-handshake writes
module text_buffer_arbiter
  import lcd_text_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int CHAR_WIDTH = DEFAULT_CHAR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  scan_req,
  input  logic [ADDR_WIDTH-1:0] scan_addr,
  output logic [CHAR_WIDTH-1:0] scan_data,
  output logic                  scan_valid,
  input  logic [31:0]           gp_cmd,
  output logic [31:0]           gp_status,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [CHAR_WIDTH-1:0] ram_wdata,
  input  logic [CHAR_WIDTH-1:0] ram_rdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [1:0]            RESYNC_END = 2'(RESYNC_CYCLES - 1);

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  ack_q, ack_d;
  logic [1:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CHAR_WIDTH-1:0] char_q, char_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [ADDR_WIDTH-1:0] cptr_q, cptr_d;
  logic                  scan_valid_q, scan_valid_d;

  logic                  tog_s;
  logic                  pending;
  logic                  busy;
  logic                  fsm_we;
  logic [ADDR_WIDTH-1:0] fsm_addr;
  logic                  unused_cmd_bits;

  toggle_synchronizer u_tog_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (gp_cmd[CMD_TOGGLE_BIT]),
    .sync_out (tog_s)
  );

  assign pending = tog_s ^ ack_q;
  assign busy    = (state_q != ST_IDLE) || pending;

  // Fields of gp_cmd that carry no meaning for this block.
  assign unused_cmd_bits = ^{gp_cmd[28], gp_cmd[15:7]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ack_d    = ack_q;
    op_d     = op_q;
    addr_d   = addr_q;
    char_d   = char_q;
    waddr_d  = waddr_q;
    cptr_d   = cptr_q;
    fsm_we   = 1'b0;
    fsm_addr = '0;

    case (state_q)
      // Acking whatever toggle is seen after reset discards a command left over from before it.
      ST_RESYNC: begin
        if (cnt_q == RESYNC_END) begin
          ack_d   = tog_s;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_IDLE: begin
        if (pending) begin
          op_d    = gp_cmd[CMD_OP_LSB +: 2];
          addr_d  = gp_cmd[CMD_ADDR_LSB +: ADDR_WIDTH];
          char_d  = gp_cmd[CMD_CHAR_LSB +: CHAR_WIDTH];
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_NOP: begin
            ack_d   = tog_s;
            state_d = ST_IDLE;
          end
          OP_SETADDR: begin
            waddr_d = (addr_q <= LAST_ADDR) ? addr_q : '0;
            ack_d   = tog_s;
            state_d = ST_IDLE;
          end
          OP_WRITE: begin
            if (!scan_req) begin
              fsm_we   = 1'b1;
              fsm_addr = waddr_q;
              waddr_d  = (waddr_q == LAST_ADDR) ? '0 : waddr_q + 1'b1;
              ack_d    = tog_s;
              state_d  = ST_IDLE;
            end
          end
          default: begin
            cptr_d  = '0;
            state_d = ST_CLEAR;
          end
        endcase
      end
      ST_CLEAR: begin
        if (!scan_req) begin
          fsm_we   = 1'b1;
          fsm_addr = cptr_q;
          if (cptr_q == LAST_ADDR) begin
            waddr_d = '0;
            ack_d   = tog_s;
            state_d = ST_IDLE;
          end else begin
            cptr_d = cptr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_RESYNC;
      end
    endcase
  end

  // Scanout owns the port whenever it asks; the FSM only writes in the gaps.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (scan_req) begin
      ram_addr = scan_addr;
    end else if (fsm_we) begin
      ram_addr  = fsm_addr;
      ram_we    = 1'b1;
      ram_wdata = char_q;
    end
  end

  assign scan_valid_d = scan_req;
  assign scan_valid   = scan_valid_q;
  assign scan_data    = scan_valid_q ? ram_rdata : '0;

  always_comb begin
    gp_status                                = '0;
    gp_status[STAT_ACK_BIT]                  = ack_q;
    gp_status[STAT_BUSY_BIT]                 = busy;
    gp_status[STAT_WADDR_LSB +: ADDR_WIDTH]  = waddr_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RESYNC;
      cnt_q        <= '0;
      ack_q        <= 1'b0;
      op_q         <= OP_NOP;
      addr_q       <= '0;
      char_q       <= '0;
      waddr_q      <= '0;
      cptr_q       <= '0;
      scan_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      char_q       <= char_d;
      waddr_q      <= waddr_d;
      cptr_q       <= cptr_d;
      scan_valid_q <= scan_valid_d;
    end
  end

endmodule
